// File: rtl/tcd1290d_line_capture.sv
// TCD1290D line capture: frames CCD lines from sh/rs, averages optical-black
// pixels, subtracts the black level and streams one AXI-Stream packet per line.
module tcd1290d_line_capture #(
    parameter int DATA_WIDTH = 12,
    parameter int DUMMY_LEAD = 32,
    parameter int OB_START   = 8,
    parameter int OB_NUM     = 16,
    parameter int PIX_NUM    = 3000,
    parameter int SAMPLE_DLY = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  sh,
    input  logic                  rs,
    input  logic [DATA_WIDTH-1:0] adc_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic [DATA_WIDTH-1:0] ob_level,
    output logic                  overflow,
    output logic                  line_trunc
);

    localparam int OB_SH = $clog2(OB_NUM);
    localparam int ACC_W = DATA_WIDTH + OB_SH;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int FW    = DATA_WIDTH + 2;
    localparam logic [11:0] OB_LO     = 12'(OB_START);
    localparam logic [11:0] OB_HI     = 12'(OB_START + OB_NUM);
    localparam logic [11:0] LEAD_LAST = 12'(DUMMY_LEAD - 1);
    localparam logic [11:0] PIX_LAST  = 12'(PIX_NUM - 1);
    localparam logic [AW:0] FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LEAD, ACTIVE, DONE} state_t;

    function automatic logic [DATA_WIDTH-1:0] sat_sub(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        logic signed [DATA_WIDTH:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        return diff[DATA_WIDTH] ? '0 : diff[DATA_WIDTH-1:0];
    endfunction

    state_t              state;
    logic                sh_d, rs_d;
    logic                sh_rise, rs_fall, smp;
    logic [11:0]         pix_cnt;
    logic                in_ob;
    logic [ACC_W-1:0]    acc, acc_next;
    logic                push_vld_p1;
    logic [FW-1:0]       push_data_p1;
    logic [FW-1:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count;
    logic                fifo_wr, fifo_rd, fifo_full;
    logic [FW-1:0]       head;

    // Edge detection on the driver gates
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            sh_d <= 1'b0;
            rs_d <= 1'b0;
        end else begin
            sh_d <= sh;
            rs_d <= rs;
        end
    end

    assign sh_rise = ~sh_d & sh;
    assign rs_fall = rs_d & ~rs;

    generate
        if (SAMPLE_DLY == 0) begin : g_nodly
            assign smp = rs_fall;
        end else begin : g_dly
            logic [SAMPLE_DLY-1:0] dly;
            always_ff @(posedge sys_clk or posedge reset) begin
                if (reset) begin
                    dly <= '0;
                end else begin
                    dly[0] <= rs_fall;
                    for (int i = 1; i < SAMPLE_DLY; i++) dly[i] <= dly[i-1];
                end
            end
            assign smp = dly[SAMPLE_DLY-1];
        end
    endgenerate

    // Sample stage: the current ADC word joins the accumulator at the same edge
    assign in_ob = (pix_cnt >= OB_LO) && (pix_cnt < OB_HI);

    always_comb begin
        acc_next = acc;
        if (in_ob) acc_next = acc + {{OB_SH{1'b0}}, adc_data};
    end

    // pix_cnt restarts at 0 on entering ACTIVE so it doubles as the active index
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pix_cnt     <= '0;
            ob_level    <= '0;
            line_trunc  <= 1'b0;
            push_vld_p1 <= 1'b0;
        end else begin
            push_vld_p1 <= 1'b0;
            if (sh_rise) begin
                pix_cnt <= '0;
                if (state == IDLE) begin
                    if (enable) state <= LEAD;
                end else begin
                    if (state != DONE) line_trunc <= 1'b1;
                    state <= enable ? LEAD : IDLE;
                end
            end else if (smp) begin
                case (state)
                    LEAD: begin
                        if (pix_cnt == LEAD_LAST) begin
                            ob_level <= acc_next[ACC_W-1:OB_SH];
                            pix_cnt  <= '0;
                            state    <= ACTIVE;
                        end else begin
                            pix_cnt <= pix_cnt + 12'd1;
                        end
                    end
                    ACTIVE: begin
                        push_vld_p1 <= 1'b1;
                        pix_cnt     <= pix_cnt + 12'd1;
                        if (pix_cnt == PIX_LAST) state <= DONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sh_rise) acc <= '0;
        else if (smp && state == LEAD) acc <= acc_next;
        if (smp && state == ACTIVE)
            push_data_p1 <= {sat_sub(adc_data, ob_level), pix_cnt == 12'd0, pix_cnt == PIX_LAST};
        if (fifo_wr) mem[wr_ptr] <= push_data_p1;
    end

    // Output FIFO: a pop in the same cycle frees the slot for a push when full
    assign fifo_full = (count == FULL_CNT);
    assign fifo_rd   = (count != '0) & m_axis_tready;
    assign fifo_wr   = push_vld_p1 & (~fifo_full | fifo_rd);

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_wr, fifo_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_vld_p1 && !fifo_wr) overflow <= 1'b1;
        end
    end

    assign head          = mem[rd_ptr];
    assign m_axis_tvalid = (count != '0);
    assign m_axis_tdata  = m_axis_tvalid ? head[FW-1:2] : '0;
    assign m_axis_tuser  = m_axis_tvalid & head[1];
    assign m_axis_tlast  = m_axis_tvalid & head[0];

endmodule

// File: tb/tb_tcd1290d_line_capture.sv
// Bench for tcd1290d_line_capture: table-driven line scenarios plus hand-written
// reset, truncation, backpressure and enable sequences, checked through a beat queue.
module tb_tcd1290d_line_capture;

    localparam int DW         = 12;
    localparam int DUMMY_LEAD = 32;
    localparam int OB_START   = 8;
    localparam int OB_NUM     = 16;
    localparam int PIX_NUM    = 3000;
    localparam int SAMPLE_DLY = 2;
    localparam int FIFO_DEPTH = 16;

    logic          sys_clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          sh;
    logic          rs;
    logic [DW-1:0] adc_data;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tuser;
    logic          m_axis_tlast;
    logic [DW-1:0] ob_level;
    logic          overflow;
    logic          line_trunc;

    always #5 sys_clk = ~sys_clk;

    tcd1290d_line_capture #(
        .DATA_WIDTH(DW), .DUMMY_LEAD(DUMMY_LEAD), .OB_START(OB_START), .OB_NUM(OB_NUM),
        .PIX_NUM(PIX_NUM), .SAMPLE_DLY(SAMPLE_DLY), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .sys_clk(sys_clk), .reset(reset), .enable(enable), .sh(sh), .rs(rs),
        .adc_data(adc_data), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .ob_level(ob_level), .overflow(overflow), .line_trunc(line_trunc)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          u;
        logic          l;
    } beat_t;

    typedef struct {
        int ob_a;
        int ob_b;
        int act_base;
        int act_step;
        int exp_ob;
    } row_t;

    beat_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_beats = 0;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per transferred beat, and checks hold-stability
    logic  hold_prev = 1'b0;
    beat_t held;
    always @(negedge sys_clk) begin : mon
        beat_t e;
        beat_t got;
        got = '{d: m_axis_tdata, u: m_axis_tuser, l: m_axis_tlast};
        if (!reset && m_axis_tvalid) begin
            if (hold_prev) begin
                n_tests++;
                if (got !== held) begin
                    n_fail++;
                    $display("FAIL hold_stable: got d=%0d u=%0d l=%0d, required d=%0d u=%0d l=%0d",
                             got.d, got.u, got.l, held.d, held.u, held.l);
                end
            end
            if (m_axis_tready) begin
                n_beats++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got d=%0d u=%0d l=%0d, required no beat",
                             got.d, got.u, got.l);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL beat: got d=%0d u=%0d l=%0d, required d=%0d u=%0d l=%0d",
                                 got.d, got.u, got.l, e.d, e.u, e.l);
                    end
                end
            end
        end
        hold_prev = !reset && m_axis_tvalid && !m_axis_tready;
        held      = got;
    end

    function automatic int sat_model(input int a, input int b);
        return (a > b) ? a - b : 0;
    endfunction

    task automatic push_exp(input int d, input logic u, input logic l);
        beat_t b;
        b.d = d[DW-1:0];
        b.u = u;
        b.l = l;
        exp_q.push_back(b);
    endtask

    // One pixel period of 4 cycles; rs falls right after a clock edge
    task automatic pixel(input int v);
        adc_data = v[DW-1:0];
        rs = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1 rs = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
    endtask

    task automatic pixel_measure(input int v);
        int j;
        adc_data = v[DW-1:0];
        rs = 1'b0;
        @(posedge sys_clk);
        j = 0;
        while (j < 12) begin
            @(negedge sys_clk);
            if (m_axis_tvalid) break;
            @(posedge sys_clk);
            j++;
        end
        check("latency_rs_to_tvalid", j + 1, SAMPLE_DLY + 2);
        @(posedge sys_clk);
        #1 rs = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
    endtask

    task automatic start_line();
        sh = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1 sh = 1'b0;
        @(posedge sys_clk);
        #1;
    endtask

    // Dummy pixels outside the OB window carry 4000 so a misplaced window shows up
    task automatic lead(input int ob_a, input int ob_b);
        for (int j = 0; j < DUMMY_LEAD; j++) begin
            if (j >= OB_START && j < OB_START + OB_NUM)
                pixel(((j - OB_START) % 2 == 0) ? ob_a : ob_b);
            else
                pixel(4000);
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge sys_clk);
        check("drain_pending", exp_q.size(), 0);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tvalid"}, int'(m_axis_tvalid), 0);
        check({tag, "_tdata"}, int'(m_axis_tdata), 0);
        check({tag, "_tuser"}, int'(m_axis_tuser), 0);
        check({tag, "_tlast"}, int'(m_axis_tlast), 0);
        check({tag, "_ob_level"}, int'(ob_level), 0);
        check({tag, "_overflow"}, int'(overflow), 0);
        check({tag, "_line_trunc"}, int'(line_trunc), 0);
    endtask

    initial begin
        row_t rows[3];
        int   b0;
        int   a;

        rows[0] = '{ob_a: 64,  ob_b: 64,   act_base: 100,  act_step: 1, exp_ob: 64};
        rows[1] = '{ob_a: 200, ob_b: 200,  act_base: 150,  act_step: 0, exp_ob: 200};
        rows[2] = '{ob_a: 0,   ob_b: 4095, act_base: 2000, act_step: 1, exp_ob: 2047};

        reset = 1'b1; enable = 1'b1; sh = 1'b0; rs = 1'b1;
        adc_data = '0; m_axis_tready = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 check_all_zero("in_reset");
        reset = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1 check_all_zero("after_reset");

        // Fill state, then assert reset in the middle of a clock period
        m_axis_tready = 1'b0;
        start_line();
        lead(300, 300);
        check("pre_reset_ob_level", int'(ob_level), 300);
        for (int i = 0; i < 24; i++) pixel(1000 + i);
        check("pre_reset_tvalid", int'(m_axis_tvalid), 1);
        check("pre_reset_overflow", int'(overflow), 1);
        start_line();
        check("pre_reset_line_trunc", int'(line_trunc), 1);
        @(negedge sys_clk);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1 reset = 1'b0;
        m_axis_tready = 1'b1;
        b0 = n_beats;
        for (int i = 0; i < 40; i++) pixel(500);
        check("no_sh_tvalid", int'(m_axis_tvalid), 0);
        check("no_sh_beats", n_beats - b0, 0);

        for (int r = 0; r < 3; r++) begin
            start_line();
            lead(rows[r].ob_a, rows[r].ob_b);
            for (int i = 0; i < PIX_NUM; i++) begin
                a = (rows[r].act_base + rows[r].act_step * i) & 4095;
                push_exp(sat_model(a, rows[r].exp_ob), i == 0, i == PIX_NUM - 1);
                if (r == 0 && i == 0) pixel_measure(a);
                else pixel(a);
            end
            wait_drain();
            check($sformatf("row%0d_ob_level", r), int'(ob_level), rows[r].exp_ob);
        end
        check("lines_line_trunc", int'(line_trunc), 0);
        check("lines_overflow", int'(overflow), 0);

        // Truncation after 100 active pixels; next line starts with tuser
        start_line();
        lead(100, 100);
        for (int i = 0; i < 100; i++) begin
            push_exp(400 + i, i == 0, 1'b0);
            pixel(500 + i);
        end
        wait_drain();
        check("trunc_before", int'(line_trunc), 0);
        start_line();
        check("trunc_after", int'(line_trunc), 1);

        // Backpressure across 20 active pixels: 16 held, 4 dropped
        lead(100, 100);
        m_axis_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i < FIFO_DEPTH) push_exp(500 + i, i == 0, 1'b0);
            pixel(600 + i);
        end
        check("bp_overflow", int'(overflow), 1);
        check("bp_tvalid", int'(m_axis_tvalid), 1);
        check("bp_head_tdata", int'(m_axis_tdata), 500);
        m_axis_tready = 1'b1;
        for (int i = 20; i < 30; i++) begin
            push_exp(500 + i, 1'b0, 1'b0);
            pixel(600 + i);
        end
        wait_drain();

        // enable low at sh_rise: the line produces nothing
        enable = 1'b0;
        start_line();
        b0 = n_beats;
        for (int i = 0; i < 40; i++) pixel(700);
        check("disabled_tvalid", int'(m_axis_tvalid), 0);
        check("disabled_beats", n_beats - b0, 0);

        // enable dropped mid-line: the line still completes with tlast
        enable = 1'b1;
        start_line();
        lead(64, 64);
        b0 = n_beats;
        for (int i = 0; i < PIX_NUM; i++) begin
            if (i == 10) enable = 1'b0;
            a = (2000 + i) & 4095;
            push_exp(sat_model(a, 64), i == 0, i == PIX_NUM - 1);
            pixel(a);
        end
        wait_drain();
        check("midline_disable_beats", n_beats - b0, PIX_NUM);
        check("midline_disable_ob_level", int'(ob_level), 64);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
